// File: rtl/jtag_pp_buffer.sv
// Dual-bank ping-pong word buffer between the JTAG Chain1 buffer port and a DMA engine.
// The JTAG side owns bank jtag_bank and the DMA side owns the other bank. Swaps are gated by dma_busy.
module jtag_pp_buffer #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  JTCK,
  input  logic                  JRSTN,
  input  logic [ADDR_WIDTH-1:0] pp_address,
  input  logic                  pp_writeEnable,
  input  logic [DATA_WIDTH-1:0] pp_dataIn,
  output logic [DATA_WIDTH-1:0] pp_dataOut,
  input  logic                  pp_switch,
  output logic                  switch_ready,
  input  logic                  dma_busy,
  input  logic [ADDR_WIDTH-1:0] dma_address,
  input  logic                  dma_writeEnable,
  input  logic [DATA_WIDTH-1:0] dma_dataIn,
  output logic [DATA_WIDTH-1:0] dma_dataOut,
  output logic [ADDR_WIDTH:0]   dma_word_count,
  output logic                  dma_bank_valid,
  output logic                  jtag_bank
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  logic [DATA_WIDTH-1:0] bank0_mem [DEPTH];
  logic [DATA_WIDTH-1:0] bank1_mem [DEPTH];

  state_e                state_q, state_d;
  logic                  jbank_q, jbank_d;
  logic                  sw_q;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH:0]   jcount_q, jcount_d;
  logic [ADDR_WIDTH:0]   dcount_q, dcount_d;
  logic [DATA_WIDTH-1:0] pp_rd_q, dma_rd_q;

  logic                  sw_edge_s;
  logic [ADDR_WIDTH:0]   addr_plus_s;
  logic [ADDR_WIDTH:0]   fill_s;
  logic                  b0_we_s, b1_we_s;
  logic [ADDR_WIDTH-1:0] b0_addr_s, b1_addr_s;
  logic [DATA_WIDTH-1:0] b0_din_s, b1_din_s;

  assign sw_edge_s   = pp_switch & ~sw_q;
  assign addr_plus_s = {1'b0, pp_address} + (ADDR_WIDTH+1)'(1);

  // Route each bank's single write port to whichever side currently owns it.
  always_comb begin
    b0_we_s   = 1'b0;
    b0_addr_s = pp_address;
    b0_din_s  = pp_dataIn;
    b1_we_s   = 1'b0;
    b1_addr_s = dma_address;
    b1_din_s  = dma_dataIn;
    if (jbank_q == 1'b0) begin
      b0_we_s   = pp_writeEnable;
      b0_addr_s = pp_address;
      b0_din_s  = pp_dataIn;
      b1_we_s   = dma_writeEnable;
      b1_addr_s = dma_address;
      b1_din_s  = dma_dataIn;
    end else begin
      b0_we_s   = dma_writeEnable;
      b0_addr_s = dma_address;
      b0_din_s  = dma_dataIn;
      b1_we_s   = pp_writeEnable;
      b1_addr_s = pp_address;
      b1_din_s  = pp_dataIn;
    end
  end

  // Bank storage; contents survive reset.
  always_ff @(posedge JTCK) begin
    if (b0_we_s) begin
      bank0_mem[b0_addr_s] <= b0_din_s;
    end
    if (b1_we_s) begin
      bank1_mem[b1_addr_s] <= b1_din_s;
    end
  end

  // Fill count already includes this cycle's write, so a write in the swap cycle is handed over.
  always_comb begin
    fill_s   = jcount_q;
    state_d  = state_q;
    jbank_d  = jbank_q;
    jcount_d = jcount_q;
    dcount_d = dcount_q;
    valid_d  = 1'b0;
    if (pp_writeEnable && (addr_plus_s > jcount_q)) begin
      fill_s = addr_plus_s;
    end else begin
      fill_s = jcount_q;
    end
    jcount_d = fill_s;
    case (state_q)
      ST_IDLE: begin
        if (sw_edge_s) begin
          state_d = ST_PENDING;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (!dma_busy) begin
          state_d  = ST_IDLE;
          jbank_d  = ~jbank_q;
          dcount_d = fill_s;
          jcount_d = '0;
          valid_d  = 1'b1;
        end else begin
          state_d = ST_PENDING;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // Control state and registered outputs; reads see the pre-write word (read-before-write).
  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      state_q  <= ST_IDLE;
      jbank_q  <= 1'b0;
      sw_q     <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      jcount_q <= '0;
      dcount_q <= '0;
      pp_rd_q  <= '0;
      dma_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      jbank_q  <= jbank_d;
      sw_q     <= pp_switch;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      jcount_q <= jcount_d;
      dcount_q <= dcount_d;
      pp_rd_q  <= jbank_q ? bank1_mem[pp_address] : bank0_mem[pp_address];
      dma_rd_q <= jbank_q ? bank0_mem[dma_address] : bank1_mem[dma_address];
    end
  end

  assign pp_dataOut     = pp_rd_q;
  assign dma_dataOut    = dma_rd_q;
  assign switch_ready   = ready_q;
  assign dma_bank_valid = valid_q;
  assign dma_word_count = dcount_q;
  assign jtag_bank      = jbank_q;

endmodule
